// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/fa_mux.sv
// 1-bit full adder built only from 2:1 muxes around a propagate term.
// Purely combinational; no latency, no flow control.
module fa_mux (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign sum  = cin ? ~p : p;
   // Propagate passes the incoming carry; otherwise a==b and a is the carry.
   assign cout = p ? cin : a;

endmodule

// File: rtl/serial_adder_mux.sv
// Bit-serial add/sub, LSB first, one bit per clock through a single fa_mux cell.
// done pulses WIDTH+1 cycles after start is taken; start is ignored while an operation runs.
module serial_adder_mux
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] s_shift;
   logic [WIDTH-1:0] s_shift_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             c_msb_in;
   logic             sum_bit;
   logic             cout_bit;
   logic             load;
   logic             step;
   logic             finish;
   logic             busy_nxt;

   fa_mux u_fa (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .sum  (sum_bit),
      .cout (cout_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy stays low in the cycle after DONE so it never overlaps the done pulse.
   always_comb begin
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE: load = start;
         RUN:  step = 1'b1;
         DONE: begin
            finish = 1'b1;
            load   = start;
         end
         default: ;
      endcase
      busy_nxt = (state_nxt == RUN) && !finish;
   end

   always_comb begin
      s_shift_nxt            = s_shift >> 1;
      s_shift_nxt[WIDTH-1]   = sum_bit;
   end

   // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         s_shift  <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
      end else if (load) begin
         op_a  <= a;
         op_b  <= b ^ {WIDTH{sub}};
         carry <= sub;
         cnt   <= '0;
      end else if (step) begin
         op_a    <= op_a >> 1;
         op_b    <= op_b >> 1;
         s_shift <= s_shift_nxt;
         carry   <= cout_bit;
         cnt     <= cnt + CNT_W'(1);
         if (cnt == LAST_BIT) begin
            c_msb_in <= carry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         s    <= '0;
         c    <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= finish;
         if (finish) begin
            s   <= s_shift;
            c   <= carry;
            ovf <= c_msb_in ^ carry;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_mux.sv
// Bench for serial_adder_mux at WIDTH 1, 8 and 16: fixed vectors, corner sequences
// and a randomised sweep against an integer-arithmetic reference.
module tb_serial_adder_mux;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        st1, sb1, a1, b1, s1, bz1, dn1, c1, ov1;
   logic        st8, sb8, bz8, dn8, c8, ov8;
   logic [7:0]  a8, b8, s8;
   logic        st16, sb16, bz16, dn16, c16, ov16;
   logic [15:0] a16, b16, s16;

   serial_adder_mux #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1), .a(a1), .b(b1),
      .busy(bz1), .done(dn1), .s(s1), .c(c1), .ovf(ov1));
   serial_adder_mux #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .a(a8), .b(b8),
      .busy(bz8), .done(dn8), .s(s8), .c(c8), .ovf(ov8));
   serial_adder_mux #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(st16), .sub(sb16), .a(a16), .b(b16),
      .busy(bz16), .done(dn16), .s(s16), .c(c16), .ovf(ov16));

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s;
      logic       c;
      logic       ov;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int w, input logic st, input logic sb,
                        input logic [15:0] a, input logic [15:0] b);
      case (w)
         1:  begin st1 = st;  sb1 = sb;  a1 = a[0];    b1 = b[0];    end
         8:  begin st8 = st;  sb8 = sb;  a8 = a[7:0];  b8 = b[7:0];  end
         default: begin st16 = st; sb16 = sb; a16 = a; b16 = b; end
      endcase
   endtask

   task automatic sample(input int w, output logic bz, output logic dn,
                         output logic [15:0] s, output logic c, output logic ov);
      case (w)
         1:  begin bz = bz1;  dn = dn1;  s = {15'd0, s1}; c = c1;  ov = ov1;  end
         8:  begin bz = bz8;  dn = dn8;  s = {8'd0, s8};  c = c8;  ov = ov8;  end
         default: begin bz = bz16; dn = dn16; s = s16; c = c16; ov = ov16; end
      endcase
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   task automatic model(input int w, input logic sub, input longint a, input longint b,
                        output logic [15:0] s, output logic c, output logic ov);
      longint m, ru, rs, sa, sb;
      m  = longint'(1) << w;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      if (sub) begin
         ru = a - b;
         c  = (a >= b);
         rs = sa - sb;
      end else begin
         ru = a + b;
         c  = (ru >= m);
         rs = sa + sb;
      end
      s  = 16'(((ru % m) + m) % m);
      ov = (rs < -(m / 2)) || (rs >= m / 2);
   endtask

   // Ticks until done; outputs must keep their previous result while waiting.
   task automatic wait_done(input int w, input logic [15:0] hs, input logic hc,
                            input logic hov, input string tag, output int n);
      logic bz, dn, c, ov;
      logic [15:0] s;
      n  = 0;
      dn = 1'b0;
      while (!dn && n < 4 * w + 16) begin
         tick();
         n++;
         sample(w, bz, dn, s, c, ov);
         if (!dn) begin
            chk({tag, " hold_s"}, 32'(s), 32'(hs));
            chk({tag, " hold_c"}, 32'(c), 32'(hc));
            chk({tag, " hold_ovf"}, 32'(ov), 32'(hov));
         end
      end
   endtask

   task automatic run_op(input int w, input logic sub, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] es, input logic ec,
                         input logic eov, input string tag);
      logic bz, dn, c, ov, hc, hov;
      logic [15:0] s, hs;
      int n;
      sample(w, bz, dn, hs, hc, hov);
      drive(w, 1'b1, sub, a, b);
      tick();
      drive(w, 1'b0, 1'b0, 16'd0, 16'd0);
      sample(w, bz, dn, s, c, ov);
      chk({tag, " busy_after_start"}, 32'(bz), 32'd1);
      wait_done(w, hs, hc, hov, tag, n);
      chk({tag, " latency"}, 32'(n), 32'(w + 1));
      sample(w, bz, dn, s, c, ov);
      chk({tag, " done"}, 32'(dn), 32'd1);
      chk({tag, " s"}, 32'(s), 32'(es));
      chk({tag, " c"}, 32'(c), 32'(ec));
      chk({tag, " ovf"}, 32'(ov), 32'(eov));
      chk({tag, " busy_at_done"}, 32'(bz), 32'd0);
      tick();
      sample(w, bz, dn, s, c, ov);
      chk({tag, " done_one_cycle"}, 32'(dn), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy_and_done_w1", 32'(bz1 & dn1), 32'd0);
         chk("busy_and_done_w8", 32'(bz8 & dn8), 32'd0);
         chk("busy_and_done_w16", 32'(bz16 & dn16), 32'd0);
      end
   end

   initial begin
      logic bz, dn, c, ov, esc, eov;
      logic [15:0] s, es;
      int n;
      vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};

      drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
      drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
      rst_n = 1'b0;
      repeat (3) tick();
      foreach (vecs[i]) begin end
      for (int w = 1; w <= 16; w++) begin
         if (w == 1 || w == 8 || w == 16) begin
            sample(w, bz, dn, s, c, ov);
            chk($sformatf("reset_w%0d busy", w), 32'(bz), 32'd0);
            chk($sformatf("reset_w%0d done", w), 32'(dn), 32'd0);
            chk($sformatf("reset_w%0d s", w), 32'(s), 32'd0);
            chk($sformatf("reset_w%0d c_ovf", w), 32'({c, ov}), 32'd0);
         end
      end
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_op(8, vecs[i].sub, {8'd0, vecs[i].a}, {8'd0, vecs[i].b},
                {8'd0, vecs[i].s}, vecs[i].c, vecs[i].ov, $sformatf("vec%0d", i));
      end

      // Back-to-back: second start presented while the first op sits in DONE.
      drive(8, 1'b1, 1'b0, 16'h00FF, 16'h0001);
      tick();
      drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      repeat (8) tick();
      drive(8, 1'b1, 1'b1, 16'h0010, 16'h0020);
      tick();
      drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      sample(8, bz, dn, s, c, ov);
      chk("b2b first done", 32'(dn), 32'd1);
      chk("b2b first s", 32'(s), 32'h00);
      chk("b2b first c_ovf", 32'({c, ov}), 32'b10);
      wait_done(8, 16'h0000, 1'b1, 1'b0, "b2b", n);
      chk("b2b latency", 32'(n), 32'd9);
      sample(8, bz, dn, s, c, ov);
      chk("b2b second done", 32'(dn), 32'd1);
      chk("b2b second s", 32'(s), 32'hF0);
      chk("b2b second c_ovf", 32'({c, ov}), 32'b00);
      tick();

      // start pulse during RUN must be dropped.
      drive(8, 1'b1, 1'b0, 16'h0001, 16'h0002);
      tick();
      drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      repeat (2) tick();
      drive(8, 1'b1, 1'b0, 16'h0000, 16'h0000);
      tick();
      drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      wait_done(8, 16'h00F0, 1'b0, 1'b0, "ignore", n);
      chk("ignore latency", 32'(n), 32'd6);
      sample(8, bz, dn, s, c, ov);
      chk("ignore s", 32'(s), 32'h03);
      chk("ignore c_ovf", 32'({c, ov}), 32'b00);
      for (int k = 0; k < 15; k++) begin
         tick();
         sample(8, bz, dn, s, c, ov);
         chk("ignore no_extra_done", 32'(dn), 32'd0);
         chk("ignore idle", 32'(bz), 32'd0);
      end

      // Reset in the middle of an operation.
      drive(8, 1'b1, 1'b0, 16'h0033, 16'h0044);
      tick();
      drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      sample(8, bz, dn, s, c, ov);
      chk("abort busy", 32'(bz), 32'd0);
      chk("abort done", 32'(dn), 32'd0);
      chk("abort s", 32'(s), 32'd0);
      chk("abort c_ovf", 32'({c, ov}), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         sample(8, bz, dn, s, c, ov);
         chk("abort no_done", 32'(dn), 32'd0);
      end

      for (int k = 0; k < 8; k++) begin
         logic sb, a, b;
         {sb, a, b} = 3'(k);
         model(1, sb, longint'(a), longint'(b), es, esc, eov);
         run_op(1, sb, {15'd0, a}, {15'd0, b}, es, esc, eov, $sformatf("w1_k%0d", k));
      end

      for (int k = 0; k < 1000; k++) begin
         logic sb;
         logic [15:0] a, b;
         sb = 1'($urandom_range(0, 1));
         a  = 16'($urandom_range(0, 65535));
         b  = 16'($urandom_range(0, 65535));
         model(16, sb, longint'(a), longint'(b), es, esc, eov);
         run_op(16, sb, a, b, es, esc, eov, $sformatf("rnd%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
